// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard controller for a 5-stage in-order core. It decides,
//   each cycle, whether the front end advances, stalls or flushes.
//   Three hazard classes, highest priority first:
//     1. multi-cycle EX op: freezes PC, IF/ID and ID/EX for MUL_LATENCY
//        cycles and bubbles EX/MEM. It is tracked by a two-state FSM
//        (RUN / MUL_WAIT) and a 4-bit down-counter.
//     2. load-use: freezes PC and IF/ID and injects a bubble into ID/EX.
//     3. taken branch: flushes IF/ID and steers the PC to the branch target.
//   All control outputs are combinational from state, cnt and the current
//   inputs, so the response takes effect in the same cycle.
//   Stall_Cycles counts the cycles with PC_Write=0. It saturates at 0xFFFF
//   and Stall_Clr clears it; a clear wins over an increment.
//
// Parameters
//   MUL_LATENCY   stall length of a multi-cycle op, 1..15
// Ports
//   clk, rst_n                         clock, async active-low reset
//   IFID_RegRs/RegRt/UsesRt            source operands of the ID instruction
//   IDEX_MemRead/RegWrite/DestReg      producer info of the EX instruction
//   IDEX_MulStart                      EX instruction is a multi-cycle op
//   Branch_Taken                       branch resolved taken in ID
//   Stall_Clr                          synchronous clear of Stall_Cycles
//   PC_Write, IFID_Write, IDEX_Write   pipeline load enables
//   IFID_Flush, PC_BranchSel           branch redirect controls
//   IDEX_Bubble, EXMEM_Bubble          control-field zeroing
//   Busy                               FSM is in MUL_WAIT (state visibility)
//   Mul_Done                           multi-cycle result valid, one cycle
//   Stall_Cycles                       saturating stall-cycle counter
module hazard_stall_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_RegRs,
  input  logic [4:0]  IFID_RegRt,
  input  logic        IFID_UsesRt,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_DestReg,
  input  logic        IDEX_MulStart,
  input  logic        Branch_Taken,
  input  logic        Stall_Clr,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        PC_BranchSel,
  output logic        IDEX_Write,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        Busy,
  output logic        Mul_Done,
  output logic [15:0] Stall_Cycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // The start cycle is itself a stall cycle. Loading MUL_LATENCY-1 gives
  // MUL_LATENCY stall cycles in total, and the cnt==0 cycle is the release.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;
  logic       mul_stall;
  logic       id_free;

  assign load_use = IDEX_MemRead & IDEX_RegWrite & (IDEX_DestReg != 5'd0) &
                    ((IDEX_DestReg == IFID_RegRs) |
                     (IFID_UsesRt & (IDEX_DestReg == IFID_RegRt)));

  assign Busy = (state == MUL_WAIT);

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    PC_BranchSel = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    Mul_Done     = 1'b0;
    mul_stall    = 1'b0;
    id_free      = 1'b0;
    // While reset is held, every output stays at its pass-through default.
    if (rst_n) begin
      case (state)
        RUN: begin
          if (IDEX_MulStart) mul_stall = 1'b1;
          else               id_free   = 1'b1;
        end
        MUL_WAIT: begin
          // Release cycle: ID is free again, so a branch or load-use that was
          // suppressed during the wait is evaluated here. MulStart is ignored
          // so the op cannot retrigger itself.
          if (cnt != 4'd0) begin
            mul_stall = 1'b1;
          end else begin
            Mul_Done = 1'b1;
            id_free  = 1'b1;
          end
        end
        default: ;
      endcase

      if (mul_stall) begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
      end else if (id_free && load_use) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else if (id_free && Branch_Taken) begin
        IFID_Flush   = 1'b1;
        PC_BranchSel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (IDEX_MulStart) begin
            state <= MUL_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        MUL_WAIT: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Cycles <= 16'd0;
    end else if (Stall_Clr) begin
      Stall_Cycles <= 16'd0;
    end else if (!PC_Write && (Stall_Cycles != 16'hFFFF)) begin
      Stall_Cycles <= Stall_Cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Bench for hazard_stall_unit. u_dut uses MUL_LATENCY=4 and is tracked by
//   a reference model. u_dut1 uses MUL_LATENCY=1 and is checked in directed
//   tests. Inputs are driven on the falling edge and outputs are sampled
//   1 ns later.
module tb_hazard_stall_unit;

  localparam int L = 4;

  // Packed output order: {PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
  //   PC_BranchSel, IDEX_Bubble, EXMEM_Bubble, Busy, Mul_Done}
  localparam logic [8:0] V_DEF = 9'b111_0000_00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  IFID_RegRs = '0, IFID_RegRt = '0, IDEX_DestReg = '0;
  logic        IFID_UsesRt = 1'b0, IDEX_MemRead = 1'b0, IDEX_RegWrite = 1'b0;
  logic        IDEX_MulStart = 1'b0, Branch_Taken = 1'b0, Stall_Clr = 1'b0;

  logic        PC_Write, IFID_Write, IFID_Flush, PC_BranchSel, IDEX_Write;
  logic        IDEX_Bubble, EXMEM_Bubble, Busy, Mul_Done;
  logic [15:0] Stall_Cycles;
  logic        d1_PC_Write, d1_IFID_Write, d1_IFID_Flush, d1_PC_BranchSel;
  logic        d1_IDEX_Write, d1_IDEX_Bubble, d1_EXMEM_Bubble, d1_Busy, d1_Mul_Done;
  logic [15:0] d1_Stall_Cycles;
  logic [8:0]  obs, obs1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state. m_since is -1 when no multi-cycle op is active.
  // Otherwise it is the number of cycles since the op started.
  int         m_since = -1;
  int         m_stall = 0;
  logic [8:0] cv;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MUL_LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_DestReg(IDEX_DestReg), .IDEX_MulStart(IDEX_MulStart),
    .Branch_Taken(Branch_Taken), .Stall_Clr(Stall_Clr),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .PC_BranchSel(PC_BranchSel), .IDEX_Write(IDEX_Write),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble), .Busy(Busy),
    .Mul_Done(Mul_Done), .Stall_Cycles(Stall_Cycles)
  );

  hazard_stall_unit #(.MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_DestReg(IDEX_DestReg), .IDEX_MulStart(IDEX_MulStart),
    .Branch_Taken(Branch_Taken), .Stall_Clr(Stall_Clr),
    .PC_Write(d1_PC_Write), .IFID_Write(d1_IFID_Write), .IFID_Flush(d1_IFID_Flush),
    .PC_BranchSel(d1_PC_BranchSel), .IDEX_Write(d1_IDEX_Write),
    .IDEX_Bubble(d1_IDEX_Bubble), .EXMEM_Bubble(d1_EXMEM_Bubble), .Busy(d1_Busy),
    .Mul_Done(d1_Mul_Done), .Stall_Cycles(d1_Stall_Cycles)
  );

  assign obs  = {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, PC_BranchSel,
                 IDEX_Bubble, EXMEM_Bubble, Busy, Mul_Done};
  assign obs1 = {d1_PC_Write, d1_IFID_Write, d1_IDEX_Write, d1_IFID_Flush,
                 d1_PC_BranchSel, d1_IDEX_Bubble, d1_EXMEM_Bubble, d1_Busy,
                 d1_Mul_Done};

  // ---------------- reference model ----------------
  function automatic logic model_lu();
    return IDEX_MemRead && IDEX_RegWrite && (IDEX_DestReg != 0) &&
           ((IDEX_DestReg == IFID_RegRs) ||
            (IFID_UsesRt && (IDEX_DestReg == IFID_RegRt)));
  endfunction

  function automatic logic [8:0] model_out();
    logic [8:0] v;
    bit mul;
    bit free;
    v = V_DEF;
    if (!rst_n) return v;
    if (m_since < 0) begin
      mul  = IDEX_MulStart;
      free = !IDEX_MulStart;
    end else if (m_since < L) begin
      mul  = 1'b1;
      free = 1'b0;
    end else begin
      mul  = 1'b0;
      free = 1'b1;
    end
    v[1] = (m_since >= 1);
    v[0] = (m_since == L);
    if (mul)                        v[8:2] = 7'b000_0001;
    else if (free && model_lu())    v[8:2] = 7'b001_0010;
    else if (free && Branch_Taken)  v[8:2] = 7'b111_1100;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since = -1;
      m_stall = 0;
    end else begin
      cv = model_out();
      if (Stall_Clr) m_stall = 0;
      else if (!cv[8] && m_stall < 65535) m_stall = m_stall + 1;
      if (m_since < 0) begin
        if (IDEX_MulStart) m_since = 1;
      end else if (m_since >= L) begin
        m_since = -1;
      end else begin
        m_since = m_since + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic rw, input logic [4:0] dest,
                       input logic ms, input logic bt, input logic clr);
    @(negedge clk);
    IFID_RegRs = rs; IFID_RegRt = rt; IFID_UsesRt = uses;
    IDEX_MemRead = mr; IDEX_RegWrite = rw; IDEX_DestReg = dest;
    IDEX_MulStart = ms; Branch_Taken = bt; Stall_Clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    IFID_RegRs = 5'd5; IDEX_DestReg = 5'd5; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IDEX_MulStart = 1'b1; Branch_Taken = 1'b1;
    #1;
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL reset_out: got %b expected %b", obs, V_DEF); end
    n_cmp++;
    if (obs1 !== V_DEF) begin n_fail++; $display("FAIL reset_out_l1: got %b expected %b", obs1, V_DEF); end
    @(negedge clk); #1;
    n_cmp++;
    if (Stall_Cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", Stall_Cycles); end
    n_cmp++;
    if (d1_Stall_Cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_l1: got %0d expected 0", d1_Stall_Cycles); end
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, V_DEF); end
    IFID_RegRs = '0; IDEX_DestReg = '0; IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0;
    IDEX_MulStart = 1'b0; Branch_Taken = 1'b0;
    rst_n = 1'b1;
    idle();
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL post_reset: got %b expected %b", obs, V_DEF); end
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== 9'b001_0010_00) begin n_fail++; $display("FAIL load_use_out: got %b expected %b", obs, 9'b001_0010_00); end
    n_cmp++;
    if (Stall_Cycles !== 16'd0) begin n_fail++; $display("FAIL load_use_cnt0: got %0d expected 0", Stall_Cycles); end
    idle();
    n_cmp++;
    if (Stall_Cycles !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt1: got %0d expected 1", Stall_Cycles); end
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL load_use_release: got %b expected %b", obs, V_DEF); end
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL zero_reg: got %b expected %b", obs, V_DEF); end
    drive(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL unused_rt: got %b expected %b", obs, V_DEF); end
    drive(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== 9'b001_0010_00) begin n_fail++; $display("FAIL used_rt: got %b expected %b", obs, 9'b001_0010_00); end
    drive(5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL no_regwrite: got %b expected %b", obs, V_DEF); end
  endtask

  task automatic test_mul();
    logic [8:0] tbl [6];
    int c0;
    tbl[0] = 9'b000_0001_00;
    tbl[1] = 9'b000_0001_10;
    tbl[2] = 9'b000_0001_10;
    tbl[3] = 9'b000_0001_10;
    tbl[4] = 9'b111_0000_11;
    tbl[5] = V_DEF;
    idle();
    c0 = m_stall;
    for (int i = 0; i < 6; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, (i < 5), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== tbl[i]) begin n_fail++; $display("FAIL mul_cycle%0d: got %b expected %b", i, obs, tbl[i]); end
    end
    n_cmp++;
    if (Stall_Cycles !== 16'(c0 + L)) begin n_fail++; $display("FAIL mul_cnt: got %0d expected %0d", Stall_Cycles, c0 + L); end
  endtask

  task automatic test_mul_lat1();
    repeat (6) idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs1 !== 9'b000_0001_00) begin n_fail++; $display("FAIL lat1_start: got %b expected %b", obs1, 9'b000_0001_00); end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs1 !== 9'b111_0000_11) begin n_fail++; $display("FAIL lat1_done: got %b expected %b", obs1, 9'b111_0000_11); end
    idle();
    n_cmp++;
    if (obs1 !== V_DEF) begin n_fail++; $display("FAIL lat1_after: got %b expected %b", obs1, V_DEF); end
    repeat (6) idle();
  endtask

  task automatic test_priority();
    drive(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 9'b001_0010_00) begin n_fail++; $display("FAIL lu_over_branch: got %b expected %b", obs, 9'b001_0010_00); end
    drive(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 9'b111_1100_00) begin n_fail++; $display("FAIL branch_flush: got %b expected %b", obs, 9'b111_1100_00); end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 9'b000_0001_00) begin n_fail++; $display("FAIL mul_over_branch: got %b expected %b", obs, 9'b000_0001_00); end
    for (int i = 1; i < L; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== 9'b000_0001_10) begin n_fail++; $display("FAIL wait_branch%0d: got %b expected %b", i, obs, 9'b000_0001_10); end
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 9'b111_1100_11) begin n_fail++; $display("FAIL release_branch: got %b expected %b", obs, 9'b111_1100_11); end
    idle();
  endtask

  task automatic test_reset_mid_op();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL midop_reset: got %b expected %b", obs, V_DEF); end
    n_cmp++;
    if (Stall_Cycles !== 16'd0) begin n_fail++; $display("FAIL midop_cnt: got %0d expected 0", Stall_Cycles); end
    IDEX_MulStart = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      idle();
      n_cmp++;
      if (obs !== V_DEF) begin n_fail++; $display("FAIL midop_after%0d: got %b expected %b", i, obs, V_DEF); end
    end
  endtask

  task automatic test_random();
    logic [8:0] v;
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
      v = model_out();
      n_cmp++;
      if (obs !== v) begin n_fail++; $display("FAIL rand_out@%0d: got %b expected %b", i, obs, v); end
      n_cmp++;
      if (Stall_Cycles !== 16'(m_stall)) begin n_fail++; $display("FAIL rand_cnt@%0d: got %0d expected %0d", i, Stall_Cycles, m_stall); end
    end
    repeat (L + 2) idle();
  endtask

  task automatic test_counter();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    // Each load-use cycle adds one; the 65535th sample shows 0xFFFE.
    for (int i = 0; i < 65534; i++)
      drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (Stall_Cycles !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_preload: got %h expected fffe", Stall_Cycles); end
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (Stall_Cycles !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat: got %h expected ffff", Stall_Cycles); end
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (Stall_Cycles !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat_hold: got %h expected ffff", Stall_Cycles); end
    idle();
    n_cmp++;
    if (Stall_Cycles !== 16'h0000) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0000", Stall_Cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mul();
    test_mul_lat1();
    test_priority();
    test_reset_mid_op();
    test_random();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
